// File: rtl/ccx_emem_pkg.sv
// Shared types and field widths for the core-complex emem arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ccx_emem_pkg;

    // Default emem field widths for the core-complex external memory port.
    localparam int EMEM_AW      = 39;
    localparam int EMEM_DW      = 64;
    localparam int EMEM_SW      = EMEM_DW / 8;
    localparam int EMEM_TIMEOUT = 255;

    // Arbiter ownership FSM.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Next channel index after idx, wrapping at n channels.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ccx_rr_pick.sv
// Round-robin picker: first set bit of (req & ~mask) searching upward from start, wrapping.
// Latency: purely combinational.
// Backpressure: n/a; caller decides when the pick is consumed.
//
// Ports:
//   req   : request vector
//   mask  : bits excluded from the search (e.g. the channel just served)
//   start : index searched first
//   vld   : at least one unmasked request exists
//   idx   : index of the picked requester (0 when vld is low)
module ccx_rr_pick
    import ccx_emem_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          vld,
    output logic [IW-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & ~mask;

    // Walk the offsets from farthest to nearest so the nearest candidate
    // to start is the last (and therefore winning) assignment.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[(int'(start) + i) % N]) begin
                vld = 1'b1;
                idx = IW'((int'(start) + i) % N);
            end
        end
    end

endmodule

// File: rtl/ccx_emem_arbiter.sv
// N-channel round-robin arbiter sharing one emem request/grant port; owner locked until grant.
// Latency: s_req -> m_req one cycle; s_gnt same cycle as m_gnt; back-to-back owners without bubble.
// Backpressure: owner held in LOCKED until m_gnt, or aborted with s_err after TIMEOUT stalled cycles.
//
// Ports:
//   g_clk, g_reset        : clock, synchronous active-high reset
//   s_req/s_rtype/s_wen   : per-channel request, type and write enable (one bit each)
//   s_addr/s_strb/s_wdata : per-channel fields packed channel-major, channel i at [i*W +: W]
//   s_gnt                 : one-hot completion to the owner
//   s_err/s_rdata         : completion status and read data, valid with any s_gnt bit
//   m_*                   : downstream emem request; m_gnt/m_err/m_rdata downstream response
//   owner/busy            : current owner index, high while LOCKED
//   timeout_event         : one-cycle pulse when a stalled request is aborted
module ccx_emem_arbiter
    import ccx_emem_pkg::*;
#(
    parameter  int CHANNELS = 2,
    parameter  int AW       = EMEM_AW,
    parameter  int DW       = EMEM_DW,
    parameter  int TIMEOUT  = EMEM_TIMEOUT,
    localparam int OW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     g_clk,
    input  logic                     g_reset,

    input  logic [CHANNELS-1:0]      s_req,
    input  logic [CHANNELS-1:0]      s_rtype,
    input  logic [CHANNELS*AW-1:0]   s_addr,
    input  logic [CHANNELS-1:0]      s_wen,
    input  logic [CHANNELS*DW/8-1:0] s_strb,
    input  logic [CHANNELS*DW-1:0]   s_wdata,
    output logic [CHANNELS-1:0]      s_gnt,
    output logic                     s_err,
    output logic [DW-1:0]            s_rdata,

    output logic                     m_req,
    output logic                     m_rtype,
    output logic                     m_wen,
    output logic [AW-1:0]            m_addr,
    output logic [DW/8-1:0]          m_strb,
    output logic [DW-1:0]            m_wdata,
    input  logic                     m_gnt,
    input  logic                     m_err,
    input  logic [DW-1:0]            m_rdata,

    output logic [OW-1:0]            owner,
    output logic                     busy,
    output logic                     timeout_event
);

    localparam int             SW       = DW / 8;
    // Counter only needs to reach TIMEOUT; it is cleared before it could wrap.
    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT);
    localparam logic [OW-1:0]  LAST_CH  = OW'(CHANNELS - 1);

    arb_state_t    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q,    rr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          locked;
    logic          own_req;
    logic          own_gnt;
    logic          tmo_fire;
    logic          done;

    logic [CHANNELS-1:0] pick_mask;
    logic [OW-1:0]       pick_start;
    logic                pick_vld;
    logic [OW-1:0]       pick_idx;

    // Per-channel views of the packed request fields.
    logic [AW-1:0] ch_addr  [CHANNELS];
    logic [SW-1:0] ch_strb  [CHANNELS];
    logic [DW-1:0] ch_wdata [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign ch_addr[g]  = s_addr[g*AW +: AW];
        assign ch_strb[g]  = s_strb[g*SW +: SW];
        assign ch_wdata[g] = s_wdata[g*DW +: DW];
    end

    // ------------------------------------------------------------------
    // Status of the current owner
    // ------------------------------------------------------------------
    assign locked  = (state_q == ARB_LOCKED);
    assign own_req = s_req[owner_q];
    assign own_gnt = locked && own_req && m_gnt;

    // A grant arriving in the limit cycle wins over the abort.
    assign tmo_fire = locked && own_req && !m_gnt && (TIMEOUT != 0) && (cnt_q == TO_LIMIT);
    assign done     = own_gnt || tmo_fire;

    // ------------------------------------------------------------------
    // Round-robin selection. One picker serves both cases:
    //   IDLE   : search from rr_ptr+1, nothing masked
    //   LOCKED : search from owner+1 with the completing owner masked, so
    //            the handover to the next owner needs no idle cycle
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pick_mask[i] = locked && (owner_q == OW'(i));
        end
    end

    assign pick_start = locked ? OW'(rr_next(int'(owner_q), CHANNELS))
                               : OW'(rr_next(int'(rr_q), CHANNELS));

    ccx_rr_pick #(
        .N  (CHANNELS),
        .IW (OW)
    ) u_pick (
        .req   (s_req),
        .mask  (pick_mask),
        .start (pick_start),
        .vld   (pick_vld),
        .idx   (pick_idx)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= LAST_CH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_LOCKED;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end

            ARB_LOCKED: begin
                if (!own_req) begin
                    // Owner abandoned its request: release without completing.
                    state_d = ARB_IDLE;
                    rr_d    = owner_q;
                    cnt_d   = '0;
                end else if (done) begin
                    rr_d  = owner_q;
                    cnt_d = '0;
                    if (pick_vld) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Downstream request: the registered owner's fields, zero when IDLE
    // ------------------------------------------------------------------
    assign m_req   = locked && own_req && !tmo_fire;
    assign m_rtype = locked && s_rtype[owner_q];
    assign m_wen   = locked && s_wen[owner_q];
    assign m_addr  = locked ? ch_addr[owner_q]  : '0;
    assign m_strb  = locked ? ch_strb[owner_q]  : '0;
    assign m_wdata = locked ? ch_wdata[owner_q] : '0;

    // ------------------------------------------------------------------
    // Upstream completion
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            s_gnt[i] = done && (owner_q == OW'(i));
        end
    end

    // An aborted request reports an error and returns no data.
    assign s_err   = own_gnt ? m_err : tmo_fire;
    assign s_rdata = own_gnt ? m_rdata : '0;

    assign owner         = owner_q;
    assign busy          = locked;
    assign timeout_event = tmo_fire;

endmodule

// File: tb/tb_ccx_emem_arbiter.sv
// Self-checking bench for ccx_emem_arbiter (2 channels, TIMEOUT = 4).
// Cycle table of inputs and expected outputs, plus a completion scoreboard
// and a hand-written request-latency sequence.
module tb_ccx_emem_arbiter;

    localparam int CH  = 2;
    localparam int AW  = 39;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    localparam logic [AW-1:0] A0 = 39'h12_3456_7800;
    localparam logic [AW-1:0] A1 = 39'h7A_BCDE_F000;
    localparam logic [DW-1:0] W0 = 64'h0000_1111_2222_3333;
    localparam logic [DW-1:0] W1 = 64'hFFFF_EEEE_DDDD_CCCC;
    localparam logic [SW-1:0] S0 = 8'h0F;
    localparam logic [SW-1:0] S1 = 8'hF0;

    logic                g_clk = 1'b0;
    logic                g_reset;
    logic [CH-1:0]       s_req;
    logic [CH-1:0]       s_rtype;
    logic [CH*AW-1:0]    s_addr;
    logic [CH-1:0]       s_wen;
    logic [CH*SW-1:0]    s_strb;
    logic [CH*DW-1:0]    s_wdata;
    logic [CH-1:0]       s_gnt;
    logic                s_err;
    logic [DW-1:0]       s_rdata;
    logic                m_req;
    logic                m_rtype;
    logic                m_wen;
    logic [AW-1:0]       m_addr;
    logic [SW-1:0]       m_strb;
    logic [DW-1:0]       m_wdata;
    logic                m_gnt;
    logic                m_err;
    logic [DW-1:0]       m_rdata;
    logic [0:0]          owner;
    logic                busy;
    logic                timeout_event;

    always #5 g_clk = ~g_clk;

    // Channel 0: write, type 0. Channel 1: read, type 1.
    assign s_addr  = {A1, A0};
    assign s_wdata = {W1, W0};
    assign s_strb  = {S1, S0};
    assign s_wen   = 2'b01;
    assign s_rtype = 2'b10;

    ccx_emem_arbiter #(
        .CHANNELS (CH),
        .AW       (AW),
        .DW       (DW),
        .TIMEOUT  (TMO)
    ) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .s_req         (s_req),
        .s_rtype       (s_rtype),
        .s_addr        (s_addr),
        .s_wen         (s_wen),
        .s_strb        (s_strb),
        .s_wdata       (s_wdata),
        .s_gnt         (s_gnt),
        .s_err         (s_err),
        .s_rdata       (s_rdata),
        .m_req         (m_req),
        .m_rtype       (m_rtype),
        .m_wen         (m_wen),
        .m_addr        (m_addr),
        .m_strb        (m_strb),
        .m_wdata       (m_wdata),
        .m_gnt         (m_gnt),
        .m_err         (m_err),
        .m_rdata       (m_rdata),
        .owner         (owner),
        .busy          (busy),
        .timeout_event (timeout_event)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       gnt;
        logic       err;
        logic [1:0] e_sgnt;
        logic       e_mreq;
        logic       e_own;
        logic       e_busy;
        logic       e_serr;
        logic       e_tev;
    } vec_t;

    typedef struct {
        logic [1:0]    gnt;
        logic          err;
        logic [DW-1:0] rdata;
    } cpl_t;

    vec_t vq[$];
    cpl_t sb[$];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic [1:0] req, input logic gnt, input logic err,
                       input logic [1:0] sg, input logic mreq, input logic own, input logic bsy,
                       input logic serr, input logic tev);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.err = err;
        v.e_sgnt = sg; v.e_mreq = mreq; v.e_own = own; v.e_busy = bsy;
        v.e_serr = serr; v.e_tev = tev;
        vq.push_back(v);
    endtask

    // Pop the oldest expected completion whenever the DUT signals one.
    task automatic sb_check(input string tag);
        cpl_t c;
        if (s_gnt != 2'b00) begin
            check({tag, ".sb_pending"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                c = sb.pop_front();
                check({tag, ".sb_gnt"},   64'(s_gnt),   64'(c.gnt));
                check({tag, ".sb_err"},   64'(s_err),   64'(c.err));
                check({tag, ".sb_rdata"}, s_rdata,      c.rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t          v;
        cpl_t          c;
        logic [DW-1:0] rd;
        string         tag;
        int            cyc;
        logic          seen;

        g_reset = 1'b1;
        s_req   = '0;
        m_gnt   = 1'b0;
        m_err   = 1'b0;
        m_rdata = '0;

        //   rst  req    gnt   err   sgnt   mreq  own   busy  serr  tev
        // Single request on ch0, granted in its third LOCKED cycle.
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v0
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v4 back in IDLE
        // Both channels requesting, m_gnt every cycle: alternating owners, no bubble.
        add(1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v5 IDLE ignores m_gnt
        add(1'b0, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // m_err passed through
        add(1'b0, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // v9
        // ch1 locked, never granted: abort in its fifth LOCKED cycle.
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // v10
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); // v14 timeout
        add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // ch0 granted exactly in the would-be timeout cycle: grant wins.
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // v16
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // v21
        add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Owner ch0 drops its request while LOCKED; ch1 is picked afterwards.
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v23
        add(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // v25 drop
        add(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset pulsed while LOCKED: IDLE next cycle, nothing completes.
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // v29
        add(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v31
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // v33

        // Reset state.
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;
        @(negedge g_clk);
        check("rst.m_req",   64'(m_req),         64'd0);
        check("rst.busy",    64'(busy),          64'd0);
        check("rst.owner",   64'(owner),         64'd0);
        check("rst.s_gnt",   64'(s_gnt),         64'd0);
        check("rst.s_err",   64'(s_err),         64'd0);
        check("rst.s_rdata", s_rdata,            64'd0);
        check("rst.tev",     64'(timeout_event), 64'd0);
        check("rst.m_addr",  64'(m_addr),        64'd0);
        check("rst.m_wdata", m_wdata,            64'd0);
        check("rst.m_strb",  64'(m_strb),        64'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge g_clk);
            #1;
            v   = vq[i];
            rd  = {32'hC0DE_0000, 32'(i)};
            tag = $sformatf("v%0d", i);
            g_reset = v.rst;
            s_req   = v.req;
            m_gnt   = v.gnt;
            m_err   = v.err;
            m_rdata = rd;
            if (v.e_sgnt != 2'b00) begin
                c.gnt   = v.e_sgnt;
                c.err   = v.e_serr;
                c.rdata = v.e_tev ? 64'd0 : rd;
                sb.push_back(c);
            end
            @(negedge g_clk);
            check({tag, ".s_gnt"}, 64'(s_gnt),         64'(v.e_sgnt));
            check({tag, ".m_req"}, 64'(m_req),         64'(v.e_mreq));
            check({tag, ".owner"}, 64'(owner),         64'(v.e_own));
            check({tag, ".busy"},  64'(busy),          64'(v.e_busy));
            check({tag, ".tev"},   64'(timeout_event), 64'(v.e_tev));
            if (v.e_mreq) begin
                check({tag, ".m_addr"},  64'(m_addr),  64'(v.e_own ? A1 : A0));
                check({tag, ".m_wdata"}, m_wdata,      v.e_own ? W1 : W0);
                check({tag, ".m_strb"},  64'(m_strb),  64'(v.e_own ? S1 : S0));
                check({tag, ".m_wen"},   64'(m_wen),   64'(!v.e_own));
                check({tag, ".m_rtype"}, 64'(m_rtype), 64'(v.e_own));
            end
            if (!v.e_busy) begin
                check({tag, ".idle_addr"}, 64'(m_addr), 64'd0);
            end
            sb_check(tag);
        end

        // Request latency: s_req in cycle N, m_req in cycle N+1 (bounded wait).
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        s_req   = 2'b10;
        m_gnt   = 1'b0;
        m_err   = 1'b0;
        cyc     = 0;
        seen    = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge g_clk);
            if (m_req) begin
                seen = 1'b1;
            end else begin
                cyc++;
                @(posedge g_clk);
                #1;
            end
        end
        check("lat.seen",   64'(seen), 64'd1);
        check("lat.cycles", 64'(cyc),  64'd1);
        if (seen) begin
            check("lat.owner",  64'(owner),  64'd1);
            check("lat.m_addr", 64'(m_addr), 64'(A1));
            m_gnt   = 1'b1;
            m_rdata = 64'h5A5A_A5A5_0F0F_F0F0;
            c.gnt   = 2'b10;
            c.err   = 1'b0;
            c.rdata = 64'h5A5A_A5A5_0F0F_F0F0;
            sb.push_back(c);
            #1;
            sb_check("lat");
        end
        @(posedge g_clk);
        #1;
        s_req = 2'b00;
        m_gnt = 1'b0;
        @(negedge g_clk);
        check("end.busy",     64'(busy),    64'd0);
        check("end.m_req",    64'(m_req),   64'd0);
        check("end.sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
